ntt_stage_ctrl: RTL and testbench

- Sequencer that runs a complete in-place iterative radix-2 NTT/iNTT over an N-coefficient memory by driving the downstream combinational `ntt_butterfly` one butterfly per cycle.
- Issues dual reads to the coefficient memory and one read to the twiddle ROM, presents the operands to the butterfly, and writes its two results back to the same addresses.
- Sits between the polynomial memory and the butterfly; a top-level FHE controller starts it with a start/done handshake.

---
 rtl/ntt_pkg.sv | 27 ++
 rtl/ntt_addr_gen.sv | 48 ++++
 rtl/ntt_stage_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg
// Shared definitions for the NTT datapath: default coefficient width and
// transform length (shared with ntt_butterfly), the sequencer state type,
// and helpers that derive stage count and stage-counter width from N.
package ntt_pkg;

    localparam int NTT_W_DEFAULT = 32;
    localparam int NTT_N_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } ntt_ctrl_state_t;

    // Number of radix-2 stages for an N-point transform.
    function automatic int ntt_logn(input int n);
        return $clog2(n);
    endfunction

    // Width of a counter that holds a stage index 0..LOGN-1.
    function automatic int ntt_stage_w(input int n);
        return ($clog2($clog2(n)) < 1) ? 1 : $clog2($clog2(n));
    endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen
// Combinational address generator for an in-place radix-2 DIT NTT.
// Maps (stage, butterfly index j) to the two coefficient addresses and the
// twiddle index used by that butterfly.
// Ports:
//   i_stage   stage number, 0..LOGN-1
//   i_j       butterfly index within the stage, 0..N/2-1
//   o_addr_a  upper operand address  (group*2*half + k)
//   o_addr_b  lower operand address  (o_addr_a + half)
//   o_tw_idx  twiddle index          (k << (LOGN-1-stage))
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter  int N    = NTT_N_DEFAULT,
    localparam int LOGN = ntt_logn(N),
    localparam int SW   = ntt_stage_w(N)
) (
    input  logic [SW-1:0]   i_stage,
    input  logic [LOGN-2:0] i_j,
    output logic [LOGN-1:0] o_addr_a,
    output logic [LOGN-1:0] o_addr_b,
    output logic [LOGN-2:0] o_tw_idx
);

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);

    logic [LOGN-1:0] w_j;
    logic [LOGN-1:0] w_half;
    logic [LOGN-1:0] w_k;
    logic [LOGN-1:0] w_base;
    logic [SW-1:0]   w_tw_shift;

    assign w_j    = {1'b0, i_j};
    assign w_half = LOGN'(1) << i_stage;
    assign w_k    = w_j & (w_half - LOGN'(1));

    // Clearing the low 'stage' bits of j gives grp*half; doubling it gives
    // the base of the group, which spans 2*half consecutive addresses.
    assign w_base = ((w_j >> i_stage) << i_stage) << 1;

    assign o_addr_a = w_base | w_k;
    assign o_addr_b = o_addr_a + w_half;

    // k < half, so k shifted by (LOGN-1-stage) always fits in LOGN-1 bits.
    assign w_tw_shift = LAST_STAGE - i_stage;
    assign o_tw_idx   = w_k[LOGN-2:0] << w_tw_shift;

endmodule

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl
// Sequencer for a complete in-place iterative radix-2 NTT/iNTT over an
// N-coefficient memory, issuing one butterfly per cycle to an external
// combinational ntt_butterfly and writing its results back in place.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, inv_mode_in         transform request and mode (1 = inverse)
//   busy, done                 status; done pulses once at completion
//   rd_en, rd_addr_a/b         coefficient read port (1-cycle latency)
//   rd_data_a/b                coefficient read data
//   tw_addr, tw_sel, tw_data   twiddle ROM index, bank select, data
//   bf_a/b/w, bf_inv           butterfly operands and mode
//   bf_a_res, bf_b_res         butterfly results (same cycle)
//   wr_en, wr_addr_a/b         write-back strobe and addresses
//   wr_data_a/b                write-back data
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter  int W    = NTT_W_DEFAULT,
    parameter  int N    = NTT_N_DEFAULT,
    localparam int LOGN = ntt_logn(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            inv_mode_in,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    input  logic [W-1:0]    rd_data_a,
    input  logic [W-1:0]    rd_data_b,
    output logic [LOGN-2:0] tw_addr,
    output logic            tw_sel,
    input  logic [W-1:0]    tw_data,
    output logic [W-1:0]    bf_a,
    output logic [W-1:0]    bf_b,
    output logic [W-1:0]    bf_w,
    output logic            bf_inv,
    input  logic [W-1:0]    bf_a_res,
    input  logic [W-1:0]    bf_b_res,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b,
    output logic [W-1:0]    wr_data_a,
    output logic [W-1:0]    wr_data_b
);

    localparam int              SW         = ntt_stage_w(N);
    localparam logic [SW-1:0]   LAST_STAGE = SW'(LOGN - 1);
    localparam logic [LOGN-2:0] LAST_J     = '1;

    ntt_ctrl_state_t r_state;
    ntt_ctrl_state_t w_state_nxt;
    logic [SW-1:0]   r_stage;
    logic [SW-1:0]   w_stage_nxt;
    logic [LOGN-2:0] r_j;
    logic [LOGN-2:0] w_j_nxt;
    logic            r_tw_sel;
    logic            w_tw_sel_nxt;
    logic            w_issue;

    logic            r_wr_en;
    logic [LOGN-1:0] r_wr_addr_a;
    logic [LOGN-1:0] r_wr_addr_b;

    logic [LOGN-1:0] w_addr_a;
    logic [LOGN-1:0] w_addr_b;
    logic [LOGN-2:0] w_tw_idx;

    ntt_addr_gen #(
        .N (N)
    ) u_addr_gen (
        .i_stage  (r_stage),
        .i_j      (r_j),
        .o_addr_a (w_addr_a),
        .o_addr_b (w_addr_b),
        .o_tw_idx (w_tw_idx)
    );

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_stage  <= '0;
            r_j      <= '0;
            r_tw_sel <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_stage  <= w_stage_nxt;
            r_j      <= w_j_nxt;
            r_tw_sel <= w_tw_sel_nxt;
        end
    end

    // Next-state logic. The single STALL cycle after each stage lets the
    // last pair of the stage be written before the next stage can read it,
    // since the memory returns stale data on a same-cycle collision.
    always_comb begin
        w_state_nxt  = r_state;
        w_stage_nxt  = r_stage;
        w_j_nxt      = r_j;
        w_tw_sel_nxt = r_tw_sel;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt  = RUN;
                    w_stage_nxt  = '0;
                    w_j_nxt      = '0;
                    w_tw_sel_nxt = inv_mode_in;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (r_j == LAST_J) begin
                    w_j_nxt     = '0;
                    w_state_nxt = STALL;
                end else begin
                    w_j_nxt = r_j + 1'b1;
                end
            end
            STALL: begin
                if (r_stage == LAST_STAGE) begin
                    w_state_nxt = DONE;
                end else begin
                    w_stage_nxt = r_stage + SW'(1);
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_stage_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Write-back pipeline: the addresses issued this cycle are written next
    // cycle, when the read data and butterfly results are available.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en     <= 1'b0;
            r_wr_addr_a <= '0;
            r_wr_addr_b <= '0;
        end else begin
            r_wr_en <= w_issue;
            if (w_issue) begin
                r_wr_addr_a <= w_addr_a;
                r_wr_addr_b <= w_addr_b;
            end
        end
    end

    // busy covers the acceptance cycle too, hence the start term in IDLE.
    assign busy = (r_state != IDLE) || start;
    assign done = (r_state == DONE);

    assign rd_en     = w_issue;
    assign rd_addr_a = w_issue ? w_addr_a : '0;
    assign rd_addr_b = w_issue ? w_addr_b : '0;
    assign tw_addr   = w_issue ? w_tw_idx : '0;
    assign tw_sel    = r_tw_sel;

    assign bf_a   = rd_data_a;
    assign bf_b   = rd_data_b;
    assign bf_w   = tw_data;
    assign bf_inv = r_tw_sel;

    assign wr_en     = r_wr_en;
    assign wr_addr_a = r_wr_addr_a;
    assign wr_addr_b = r_wr_addr_b;
    assign wr_data_a = bf_a_res;
    assign wr_data_b = bf_b_res;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl
// Self-checking bench for ntt_stage_ctrl at N=8 over Z_17 (omega = 2).
// Surrounds the sequencer with a coefficient memory, a twiddle ROM and a
// butterfly stand-in, and checks results against a direct O(N^2) DFT.
// The inverse butterfly halves both outputs, folding 1/N into the stages.
module tb_ntt_stage_ctrl;

    localparam int W         = 32;
    localparam int N         = 8;
    localparam int LOGN      = 3;
    localparam int Q         = 17;
    localparam int OMEGA     = 2;
    localparam int OMEGA_INV = 9;
    localparam int INV2      = 9;
    localparam int NPAIRS    = LOGN * N / 2;
    localparam int BUDGET    = 60;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            inv_mode_in = 1'b0;
    logic            busy, done, rd_en, tw_sel, bf_inv, wr_en;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOGN-2:0] tw_addr;
    logic [W-1:0]    rd_data_a = '0;
    logic [W-1:0]    rd_data_b = '0;
    logic [W-1:0]    tw_data = '0;
    logic [W-1:0]    bf_a, bf_b, bf_w, bf_a_res, bf_b_res, wr_data_a, wr_data_b;

    int checks = 0;
    int failures = 0;

    ntt_stage_ctrl #(.W(W), .N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .inv_mode_in(inv_mode_in),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .tw_addr(tw_addr), .tw_sel(tw_sel), .tw_data(tw_data),
        .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_inv(bf_inv),
        .bf_a_res(bf_a_res), .bf_b_res(bf_b_res),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
    );

    // Standalone address generator probe
    logic [1:0] agStage, agJ, agTw;
    logic [2:0] agA, agB;

    ntt_addr_gen #(.N(N)) u_agen (
        .i_stage(agStage), .i_j(agJ),
        .o_addr_a(agA), .o_addr_b(agB), .o_tw_idx(agTw)
    );

    always #5 clk = ~clk;

    // Coefficient memory, twiddle ROM; stale data on read/write collision
    logic [W-1:0] mem [N];
    int           loadVec [N];
    logic         loadReq = 1'b0;
    int           fwdBank [N/2];
    int           invBank [N/2];

    always @(posedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < N; i++) mem[i] <= W'(loadVec[i]);
        end else if (wr_en) begin
            mem[wr_addr_a] <= wr_data_a;
            mem[wr_addr_b] <= wr_data_b;
        end
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
            tw_data   <= W'(tw_sel ? invBank[tw_addr] : fwdBank[tw_addr]);
        end
    end

    // Butterfly stand-in: a' = a + w*b, b' = a - w*b (halved when inverse)
    int bfProd, bfSum, bfDiff;
    always_comb begin
        bfProd = (int'(bf_w) * int'(bf_b)) % Q;
        bfSum  = (int'(bf_a) + bfProd) % Q;
        bfDiff = (int'(bf_a) + Q - bfProd) % Q;
        if (bf_inv) begin
            bfSum  = (bfSum * INV2) % Q;
            bfDiff = (bfDiff * INV2) % Q;
        end
        bf_a_res = W'(bfSum);
        bf_b_res = W'(bfDiff);
    end

    // Reference data
    int xVec [N];
    int srcVec [N];
    int refOut [N];
    int expA [NPAIRS];
    int expB [NPAIRS];
    int expTw [NPAIRS];

    function automatic int modpow(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    function automatic int bitrev3(input int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    // Direct transform of xVec into refOut (inverse includes the 1/N scale)
    task automatic compute_dft(input bit inverse);
        int acc;
        for (int m = 0; m < N; m++) begin
            acc = 0;
            for (int n = 0; n < N; n++)
                acc = (acc + xVec[n] * modpow(inverse ? OMEGA_INV : OMEGA, (n * m) % N)) % Q;
            if (inverse) acc = (acc * modpow(INV2, LOGN)) % Q;
            refOut[m] = acc;
        end
    endtask

    // Butterfly order of a textbook iterative DIT loop nest
    task automatic build_expected();
        int idx = 0;
        for (int half = 1; half < N; half = half * 2)
            for (int base = 0; base < N; base = base + 2 * half)
                for (int k = 0; k < half; k++) begin
                    expA[idx]  = base + k;
                    expB[idx]  = base + k + half;
                    expTw[idx] = k * (N / (2 * half));
                    idx++;
                end
    endtask

    task automatic load_bitrev();
        for (int n = 0; n < N; n++) loadVec[bitrev3(n)] = srcVec[n];
        @(negedge clk);
        loadReq = 1'b1;
        @(negedge clk);
        loadReq = 1'b0;
    endtask

    task automatic random_x();
        for (int n = 0; n < N; n++) begin
            xVec[n]   = int'($urandom_range(0, Q - 1));
            srcVec[n] = xVec[n];
        end
    endtask

    // Observations from the most recent run
    int   doneCnt, doneCycle, busyFirst, busyLast, busyCnt, wrCnt, rdCnt;
    int   stallCnt, stallBad, hazardCnt, addrErr, maxAddrB, twSelErr;
    logic rstRd, rstWr, rstBusy, rstDone, rstTwSel;

    // Start a transform (cycle 0 = acceptance cycle) and observe each cycle
    // until three cycles past done, the budget, or an injected reset.
    task automatic run_transform(input bit inv, input bit poke, input int resetAt);
        int pendA = -1, pendB = -1, nextA, nextB, idx = 0;
        doneCnt = 0; doneCycle = -1; busyFirst = -1; busyLast = -1; busyCnt = 0;
        wrCnt = 0; rdCnt = 0; stallCnt = 0; stallBad = 0; hazardCnt = 0;
        addrErr = 0; maxAddrB = 0; twSelErr = 0;
        @(negedge clk);
        for (int c = 0; c < BUDGET; c++) begin
            start = (c == 0) || (poke && c == 2);
            if (c == 0) inv_mode_in = inv;
            else if (poke) inv_mode_in = ($urandom_range(0, 1) == 1);
            #1;
            if (c == resetAt) begin
                reset = 1'b1;
                #1;
                rstRd = rd_en; rstWr = wr_en; rstBusy = busy;
                rstDone = done; rstTwSel = tw_sel;
                start = 1'b0;
                return;
            end
            if (busy) begin
                if (busyFirst < 0) busyFirst = c;
                busyLast = c;
                busyCnt++;
            end
            if (wr_en) wrCnt++;
            if (c > 0 && busy && !done && !rd_en) begin
                stallCnt++;
                if (!wr_en) stallBad++;
            end
            if (c > 0 && tw_sel !== inv) twSelErr++;
            nextA = -1; nextB = -1;
            if (rd_en) begin
                rdCnt++;
                if (int'(rd_addr_a) == pendA || int'(rd_addr_a) == pendB ||
                    int'(rd_addr_b) == pendA || int'(rd_addr_b) == pendB) hazardCnt++;
                if (idx < NPAIRS) begin
                    if (rd_addr_a !== LOGN'(expA[idx]) || rd_addr_b !== LOGN'(expB[idx]) ||
                        tw_addr !== (LOGN-1)'(expTw[idx])) addrErr++;
                    nextA = expA[idx]; nextB = expB[idx];
                    idx++;
                end else begin
                    addrErr++;
                end
                if (int'(rd_addr_b) > maxAddrB) maxAddrB = int'(rd_addr_b);
            end
            pendA = nextA; pendB = nextB;
            if (done) begin
                doneCnt++;
                if (doneCycle < 0) doneCycle = c;
                if (poke) start = 1'b1;
            end
            if (doneCycle >= 0 && c >= doneCycle + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobes: got rd=%b wr=%b expected 0 0", rd_en, wr_en); end
        checks++; if (tw_sel !== 1'b0) begin failures++; $display("[TB] FAIL reset_tw_sel: got %b expected 0", tw_sel); end
        checks++;
        if (rd_addr_a !== '0 || rd_addr_b !== '0 || tw_addr !== '0 || wr_addr_a !== '0 || wr_addr_b !== '0) begin
            failures++;
            $display("[TB] FAIL reset_addrs: got ra=%0d rb=%0d tw=%0d wa=%0d wb=%0d expected all 0",
                     rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_addr_gen();
        int tbl [4][5] = '{'{0, 0, 0, 1, 0}, '{0, 3, 6, 7, 0}, '{1, 1, 1, 3, 2}, '{2, 3, 3, 7, 3}};
        for (int i = 0; i < 4; i++) begin
            agStage = 2'(tbl[i][0]);
            agJ     = 2'(tbl[i][1]);
            #1;
            checks++;
            if (agA !== 3'(tbl[i][2]) || agB !== 3'(tbl[i][3]) || agTw !== 2'(tbl[i][4])) begin
                failures++;
                $display("[TB] FAIL addr_gen s%0d j%0d: got A=%0d B=%0d tw=%0d expected A=%0d B=%0d tw=%0d",
                         tbl[i][0], tbl[i][1], agA, agB, agTw, tbl[i][2], tbl[i][3], tbl[i][4]);
            end
        end
    endtask

    task automatic test_delta_forward();
        for (int n = 0; n < N; n++) srcVec[n] = (n == 0) ? 1 : 0;
        load_bitrev();
        run_transform(1'b0, 1'b0, -1);
        checks++; if (doneCycle != 16) begin failures++; $display("[TB] FAIL delta_done_cycle: got %0d expected 16", doneCycle); end
        checks++; if (doneCnt != 1) begin failures++; $display("[TB] FAIL delta_done_count: got %0d expected 1", doneCnt); end
        checks++;
        if (busyFirst != 0 || busyLast != 16 || busyCnt != 17) begin
            failures++;
            $display("[TB] FAIL delta_busy_window: got first=%0d last=%0d count=%0d expected 0 16 17", busyFirst, busyLast, busyCnt);
        end
        checks++; if (wrCnt != NPAIRS) begin failures++; $display("[TB] FAIL delta_wr_pulses: got %0d expected %0d", wrCnt, NPAIRS); end
        checks++; if (rdCnt != NPAIRS) begin failures++; $display("[TB] FAIL delta_rd_pulses: got %0d expected %0d", rdCnt, NPAIRS); end
        checks++; if (addrErr != 0) begin failures++; $display("[TB] FAIL delta_addr_seq: got %0d bad issues expected 0", addrErr); end
        checks++; if (maxAddrB != N - 1) begin failures++; $display("[TB] FAIL delta_max_addr_b: got %0d expected %0d", maxAddrB, N - 1); end
        for (int m = 0; m < N; m++) begin
            checks++;
            if (mem[m] !== W'(1)) begin failures++; $display("[TB] FAIL delta_out[%0d]: got %0d expected 1", m, mem[m]); end
        end
    endtask

    task automatic test_stage_boundary();
        random_x();
        compute_dft(1'b0);
        load_bitrev();
        run_transform(1'b0, 1'b0, -1);
        checks++; if (stallCnt != LOGN) begin failures++; $display("[TB] FAIL stall_count: got %0d expected %0d", stallCnt, LOGN); end
        checks++; if (stallBad != 0) begin failures++; $display("[TB] FAIL stall_without_write: got %0d expected 0", stallBad); end
        checks++; if (hazardCnt != 0) begin failures++; $display("[TB] FAIL read_of_pending_write: got %0d expected 0", hazardCnt); end
        for (int m = 0; m < N; m++) begin
            checks++;
            if (mem[m] !== W'(refOut[m])) begin failures++; $display("[TB] FAIL boundary_out[%0d]: got %0d expected %0d", m, mem[m], refOut[m]); end
        end
    endtask

    task automatic test_ignored_inputs();
        random_x();
        compute_dft(1'b0);
        load_bitrev();
        run_transform(1'b0, 1'b1, -1);
        checks++; if (doneCnt != 1) begin failures++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCnt); end
        checks++; if (doneCycle != 16) begin failures++; $display("[TB] FAIL ignore_done_cycle: got %0d expected 16", doneCycle); end
        checks++; if (busyLast != 16) begin failures++; $display("[TB] FAIL ignore_busy_last: got %0d expected 16", busyLast); end
        checks++; if (twSelErr != 0) begin failures++; $display("[TB] FAIL ignore_tw_sel: got %0d changed cycles expected 0", twSelErr); end
        for (int m = 0; m < N; m++) begin
            checks++;
            if (mem[m] !== W'(refOut[m])) begin failures++; $display("[TB] FAIL ignore_out[%0d]: got %0d expected %0d", m, mem[m], refOut[m]); end
        end
    endtask

    task automatic test_reset_midrun();
        random_x();
        load_bitrev();
        // Stage 1, j = 2 is cycle 8 after acceptance
        run_transform(1'b1, 1'b0, 8);
        checks++;
        if (rstRd !== 1'b0 || rstWr !== 1'b0 || rstBusy !== 1'b0 || rstDone !== 1'b0 || rstTwSel !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_reset: got rd=%b wr=%b busy=%b done=%b tw_sel=%b expected all 0",
                     rstRd, rstWr, rstBusy, rstDone, rstTwSel);
        end
        @(negedge clk);
        reset = 1'b0;
        random_x();
        compute_dft(1'b0);
        load_bitrev();
        run_transform(1'b0, 1'b0, -1);
        checks++; if (doneCnt != 1 || doneCycle != 16) begin failures++; $display("[TB] FAIL after_reset_done: got count=%0d cycle=%0d expected 1 16", doneCnt, doneCycle); end
        for (int m = 0; m < N; m++) begin
            checks++;
            if (mem[m] !== W'(refOut[m])) begin failures++; $display("[TB] FAIL after_reset_out[%0d]: got %0d expected %0d", m, mem[m], refOut[m]); end
        end
    endtask

    task automatic test_roundtrip();
        int orig [N];
        for (int v = 0; v < 3; v++) begin
            random_x();
            orig = xVec;
            compute_dft(1'b0);
            load_bitrev();
            run_transform(1'b0, 1'b0, -1);
            for (int m = 0; m < N; m++) begin
                checks++;
                if (mem[m] !== W'(refOut[m])) begin failures++; $display("[TB] FAIL fwd%0d_out[%0d]: got %0d expected %0d", v, m, mem[m], refOut[m]); end
            end
            srcVec = refOut;
            load_bitrev();
            run_transform(1'b1, 1'b0, -1);
            checks++; if (doneCycle != 16) begin failures++; $display("[TB] FAIL inv%0d_done_cycle: got %0d expected 16", v, doneCycle); end
            for (int n = 0; n < N; n++) begin
                checks++;
                if (mem[n] !== W'(orig[n])) begin failures++; $display("[TB] FAIL inv%0d_out[%0d]: got %0d expected %0d", v, n, mem[n], orig[n]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N / 2; i++) begin
            fwdBank[i] = modpow(OMEGA, i);
            invBank[i] = modpow(OMEGA_INV, i);
        end
        build_expected();
        test_reset();
        test_addr_gen();
        test_delta_forward();
        test_stage_boundary();
        test_ignored_inputs();
        test_reset_midrun();
        test_roundtrip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
